mux_bus_arbiter: RTL and testbench
==================================

// Module: mux_bus_arbiter
//
// PURPOSE
//   Round-robin arbiter/sequencer sharing one tri-state bus slice, built from
//   74x253/74x257-style muxes, between 4 requesters. Drives the mux select
//   and active-low output enable with break-before-make timing:
//   - the select is stable before the output enable goes low;
//   - the output enable is high again before the select changes.
//   Sits between the bus requesters (microcode/DMA/front panel/IRQ) and the
//   mux bank.
//
// PARAMETERS
//   SETTLE_CYC  1   cycles select is held with mux_noe=1 before grant (1..15)
//   TURN_CYC    1   bus turnaround cycles after release, mux_noe=1 (1..15)
//   MAX_HOLD    16  max GRANT cycles before preemption if others wait;
//                   0 = unlimited (0..255)
//
// PORTS
//   clk       in   1  system clock, all state changes on rising edge
//   reset     in   1  synchronous, active-high reset
//   req       in   4  request lines, level; held high for bus tenure
//   gnt       out  4  one-hot grant, registered
//   mux_sel   out  2  select to mux bank, registered
//   mux_noe   out  1  active-low mux output enable, registered
//   busy      out  1  high whenever state != IDLE
//
// BEHAVIOUR
//   Reset values: gnt=0, mux_sel=0, mux_noe=1, busy=0, state=IDLE,
//   rr pointer last=3, so req[0] has first priority. Reset mid-operation
//   forces these values at the next edge; no gnt/noe glitch beyond that edge.
//
//   States and transitions:
//   - IDLE: if |req, pick the first asserted req scanning last+1, last+2, ...
//     (mod 4). Load mux_sel=winner, go SETTLE, cnt=SETTLE_CYC-1.
//     If no req, stay in IDLE.
//   - SETTLE: mux_noe stays 1, gnt stays 0.
//     - If req[winner] drops: abort to IDLE; pointer is not updated.
//     - Else when cnt==0: go GRANT, set gnt[winner]=1, mux_noe=0,
//       last=winner, hold=0.
//     - Else decrement cnt.
//   - GRANT: hold increments and saturates.
//     - Release when req[winner]==0.
//     - Also release when MAX_HOLD!=0, hold>=MAX_HOLD-1, and another req is
//       pending.
//     - If the limit is reached with no other req pending: stay and clear hold.
//     - On release: gnt=0 and mux_noe=1 at the same edge; go TURN,
//       cnt=TURN_CYC-1.
//   - TURN: mux_sel is frozen. When cnt==0 go IDLE; else decrement cnt.
//
//   Latency:
//   - req rising at edge k, bus idle: mux_sel valid after edge k+1;
//     gnt/mux_noe=0 after edge k+1+SETTLE_CYC.
//   - Back-to-back handoff: the gap between one grant and the next is
//     TURN_CYC + 1 + SETTLE_CYC cycles.
//
//   Invariants:
//   - mux_sel never changes while mux_noe==0 or in TURN.
//   - gnt is one-hot or zero.
//   - gnt[i]==1 implies mux_sel==i and mux_noe==0.
//
//   Simultaneous events:
//   - A req arriving during SETTLE/GRANT/TURN waits; it is considered only
//     in IDLE.
//   - The grant holder dropping req the same cycle others assert gives a
//     normal release; arbitration happens in IDLE.
//   - Counters: cnt is 4-bit, hold is 8-bit saturating; no wrap-around.
//
// STRUCTURE
//   - Shared header mux_arb_defs.v, with an include guard, holds:
//     state encodings ARB_IDLE=0, ARB_SETTLE=1, ARB_GRANT=2, ARB_TURN=3,
//     and the width constants.
//   - One combinational sub-module, rr_pick4 (req[3:0], last[1:0] ->
//     any, win[1:0]), holds the rotate-priority logic.
//   - All outputs come from flops in mux_bus_arbiter.
//
// TESTING
//   - Reset: assert reset 2 cycles with req=4'b1111
//     -> gnt=0, mux_noe=1, mux_sel=0, busy=0 throughout.
//   - Single req[2] rises at edge 10, defaults -> mux_sel=2 after edge 11;
//     gnt=4'b0100 and mux_noe=0 after edge 12. Drop req at edge 20
//     -> gnt=0, mux_noe=1 after edge 21, busy=0 after edge 22.
//   - req=4'b1111 held, MAX_HOLD=16 -> grants rotate 0,1,2,3,0 with 16-cycle
//     tenures. A checker asserts mux_sel stable whenever mux_noe==0 or in TURN.
//   - req[1] alone, MAX_HOLD=4, held 50 cycles -> a single continuous grant;
//     then req[3] rises -> gnt[1] drops within 4 cycles and gnt[3] follows
//     after TURN_CYC+1+SETTLE_CYC cycles.
//   - req[0] pulses 1 cycle, SETTLE_CYC=3 -> abort: gnt never asserts, back
//     to IDLE. The next req=4'b0011 still grants req[0] first (pointer
//     unchanged).
//   - reset pulsed during GRANT of req[2] -> after that edge gnt=0,
//     mux_noe=1, mux_sel=0. With req still high, the grant re-sequences
//     from IDLE.

Source files
------------

// File: rtl/mux_bus_arbiter_pkg.sv
// rtl/mux_bus_arbiter_pkg.sv - shared widths, state codes and helpers for the bus mux arbiter
package mux_bus_arbiter_pkg;

  localparam int NREQ   = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;
  localparam int HOLD_W = 8;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_SETTLE = 2'd1;
  localparam logic [1:0] ARB_GRANT  = 2'd2;
  localparam logic [1:0] ARB_TURN   = 2'd3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NREQ-1:0]  req_t;

  // One-hot request mask for a mux select value.
  function automatic req_t onehot_of(input sel_t s);
    return req_t'(1) << s;
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_rr_pick4.sv
// rtl/mux_bus_arbiter_rr_pick4.sv - rotating-priority pick of one of four requests
module mux_bus_arbiter_rr_pick4
  import mux_bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic             o_any,
  output logic [SEL_W-1:0] o_win
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Scan last+1, last+2, ... (mod 4); the previous winner is checked last.
  always_comb begin
    o_any   = |i_req;
    o_win   = i_last;
    w_idx   = i_last;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = i_last + SEL_W'(k);
      if (!w_found && i_req[w_idx]) begin
        o_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin sequencer for a shared tri-state mux bus slice
module mux_bus_arbiter
  import mux_bus_arbiter_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int TURN_CYC   = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_gnt,
  output logic [SEL_W-1:0] o_mux_sel,
  output logic             o_mux_noe,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TURN_INIT   = CNT_W'(TURN_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM    = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [SEL_W-1:0]  r_last;
  logic [NREQ-1:0]   r_gnt;
  logic [SEL_W-1:0]  r_sel;
  logic              r_noe;
  logic              r_busy;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [SEL_W-1:0]  w_last_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic              w_noe_nxt;

  logic              w_any;
  logic [SEL_W-1:0]  w_win;
  logic              w_others;
  logic              w_limit;

  mux_bus_arbiter_rr_pick4 u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_win  (w_win)
  );

  // The current winner is always the value held on the mux select.
  assign w_others = |(i_req & ~onehot_of(r_sel));
  assign w_limit  = (MAX_HOLD != 0) && (r_hold >= HOLD_LIM);

  // Next-state logic; gnt and noe only ever change together so the bus is
  // released before the select can move and selected before it is driven.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_noe_nxt   = r_noe;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_win;
          w_state_nxt = ARB_SETTLE;
          w_cnt_nxt   = SETTLE_INIT;
        end
      end
      ARB_SETTLE: begin
        if (!i_req[r_sel]) begin
          w_state_nxt = ARB_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ARB_GRANT;
          w_gnt_nxt   = onehot_of(r_sel);
          w_noe_nxt   = 1'b0;
          w_last_nxt  = r_sel;
          w_hold_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ARB_GRANT: begin
        if (!i_req[r_sel] || (w_limit && w_others)) begin
          w_state_nxt = ARB_TURN;
          w_gnt_nxt   = '0;
          w_noe_nxt   = 1'b1;
          w_cnt_nxt   = TURN_INIT;
        end else if (w_limit) begin
          w_hold_nxt = '0;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        if (r_cnt == '0) begin
          w_state_nxt = ARB_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset parks the bus disabled on select 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_last  <= SEL_W'(NREQ - 1);
      r_gnt   <= '0;
      r_sel   <= '0;
      r_noe   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_noe   <= w_noe_nxt;
      r_busy  <= (w_state_nxt != ARB_IDLE);
    end
  end

  assign o_gnt     = r_gnt;
  assign o_mux_sel = r_sel;
  assign o_mux_noe = r_noe;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - self-checking bench for the bus mux arbiter
module tb_mux_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic [3:0] req  [3];
  logic [3:0] gnt  [3];
  logic [1:0] sel  [3];
  logic       noe  [3];
  logic       busy [3];

  // Three configurations: defaults, short hold limit, long settle/turn.
  mux_bus_arbiter u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_req(req[0]),
    .o_gnt(gnt[0]), .o_mux_sel(sel[0]), .o_mux_noe(noe[0]), .o_busy(busy[0])
  );
  mux_bus_arbiter #(.MAX_HOLD(4)) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_req(req[1]),
    .o_gnt(gnt[1]), .o_mux_sel(sel[1]), .o_mux_noe(noe[1]), .o_busy(busy[1])
  );
  mux_bus_arbiter #(.SETTLE_CYC(3), .TURN_CYC(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst[2]), .i_req(req[2]),
    .o_gnt(gnt[2]), .o_mux_sel(sel[2]), .o_mux_noe(noe[2]), .o_busy(busy[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int p_settle [3] = '{1, 1, 3};
  int p_turn   [3] = '{1, 1, 2};
  int p_hold   [3] = '{16, 4, 16};

  // Reference model: phase 0 idle, 1 settle, 2 granted, 3 turnaround.
  int         m_phase [3];
  int         m_owner [3];
  int         m_last  [3];
  int         m_timer [3];
  int         m_hold  [3];
  int         m_prev  [3];
  logic       m_rst   [3];
  logic [1:0] prev_sel[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0] r;
    int         c;
    logic       found;
    logic       others;
    logic       limit;
    r         = req[i];
    m_prev[i] = m_phase[i];
    m_rst[i]  = rst[i];
    if (rst[i]) begin
      m_phase[i] = 0; m_owner[i] = 0; m_last[i] = 3; m_timer[i] = 0; m_hold[i] = 0;
    end else begin
      case (m_phase[i])
        0: if (r != 4'b0000) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            c = (m_last[i] + k) % 4;
            if (!found && r[c]) begin
              m_owner[i] = c;
              found = 1'b1;
            end
          end
          m_phase[i] = 1;
          m_timer[i] = p_settle[i] - 1;
        end
        1: begin
          if (!r[m_owner[i]]) m_phase[i] = 0;
          else if (m_timer[i] == 0) begin
            m_phase[i] = 2; m_last[i] = m_owner[i]; m_hold[i] = 0;
          end else m_timer[i]--;
        end
        2: begin
          others = 1'b0;
          for (int k = 0; k < 4; k++) if (k != m_owner[i] && r[k]) others = 1'b1;
          limit = (p_hold[i] != 0) && (m_hold[i] >= p_hold[i] - 1);
          if (!r[m_owner[i]] || (limit && others)) begin
            m_phase[i] = 3; m_timer[i] = p_turn[i] - 1;
          end else if (limit) m_hold[i] = 0;
          else if (m_hold[i] < 255) m_hold[i]++;
        end
        default: begin
          if (m_timer[i] == 0) m_phase[i] = 0;
          else m_timer[i]--;
        end
      endcase
    end
  endtask

  task automatic compare_inst(input int i);
    logic [3:0] exp_gnt;
    exp_gnt = (m_phase[i] == 2) ? (4'b0001 << m_owner[i]) : 4'b0000;
    check($sformatf("i%0d_gnt", i), 32'(gnt[i]), 32'(exp_gnt));
    check($sformatf("i%0d_sel", i), 32'(sel[i]), 32'(m_owner[i]));
    check($sformatf("i%0d_noe", i), 32'(noe[i]), 32'(m_phase[i] != 2));
    check($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(m_phase[i] != 0));
    if (!m_rst[i] && (m_prev[i] == 2 || m_prev[i] == 3))
      check($sformatf("i%0d_sel_frozen", i), 32'(sel[i]), 32'(prev_sel[i]));
    if (gnt[i] != 4'b0000) begin
      check($sformatf("i%0d_gnt_onehot", i), 32'($onehot(gnt[i])), 32'd1);
      check($sformatf("i%0d_gnt_noe", i), 32'(noe[i]), 32'd0);
      for (int c = 0; c < 4; c++)
        if (gnt[i][c]) check($sformatf("i%0d_gnt_sel", i), 32'(sel[i]), 32'(c));
    end
    prev_sel[i] = sel[i];
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) compare_inst(i);
    cyc++;
  endtask

  task automatic wait_gnt(input int i, input logic [3:0] tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (gnt[i] !== tgt && n < budget) begin
      step();
      n++;
    end
    check({tag, "_reached"}, 32'(gnt[i] === tgt), 32'd1);
  endtask

  int         seq[$];
  int         ten[$];
  int         gap[$];
  int         rise_cyc;
  int         fall_cyc;
  logic       have_fall;
  logic [3:0] prev_g;
  int         n;
  int         m;
  int         drops;
  logic       seen;
  int         exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 4'b1111;
      m_phase[i] = 0; m_owner[i] = 0; m_last[i] = 3; m_timer[i] = 0; m_hold[i] = 0;
      m_prev[i] = 0; m_rst[i] = 1'b1; prev_sel[i] = 2'd0;
    end

    // Reset held two cycles with every request high.
    repeat (2) begin
      step();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst%0d_gnt", i), 32'(gnt[i]), 32'd0);
        check($sformatf("rst%0d_noe", i), 32'(noe[i]), 32'd1);
        check($sformatf("rst%0d_sel", i), 32'(sel[i]), 32'd0);
        check($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; req[i] = 4'b0000; end
    step(); step();

    // Lone req[2]: select after one edge, grant after settle.
    req[0] = 4'b0100;
    step();
    check("lat_sel", 32'(sel[0]), 32'd2);
    check("lat_gnt_early", 32'(gnt[0]), 32'd0);
    check("lat_noe_early", 32'(noe[0]), 32'd1);
    step();
    check("lat_gnt", 32'(gnt[0]), 32'h4);
    check("lat_noe", 32'(noe[0]), 32'd0);
    repeat (8) step();
    req[0] = 4'b0000;
    step();
    check("rel_gnt", 32'(gnt[0]), 32'd0);
    check("rel_noe", 32'(noe[0]), 32'd1);
    check("rel_busy_turn", 32'(busy[0]), 32'd1);
    step();
    check("rel_busy_idle", 32'(busy[0]), 32'd0);

    // All four requesting: rotation order, tenure and handoff gap.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    req[0] = 4'b1111;
    prev_g = 4'b0000; have_fall = 1'b0; rise_cyc = 0; fall_cyc = 0;
    repeat (100) begin
      step();
      if (prev_g == 4'b0000 && gnt[0] != 4'b0000) begin
        rise_cyc = cyc;
        if (have_fall) gap.push_back(cyc - fall_cyc);
        for (int c = 0; c < 4; c++) if (gnt[0][c]) seq.push_back(c);
      end
      if (prev_g != 4'b0000 && gnt[0] == 4'b0000) begin
        ten.push_back(cyc - rise_cyc);
        fall_cyc = cyc; have_fall = 1'b1;
      end
      prev_g = gnt[0];
    end
    check("rot_count", 32'(seq.size() >= 5 && ten.size() >= 4 && gap.size() >= 4), 32'd1);
    if (seq.size() >= 5 && ten.size() >= 4 && gap.size() >= 4) begin
      for (int k = 0; k < 5; k++) check($sformatf("rot_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
      for (int k = 0; k < 4; k++) check($sformatf("rot_tenure%0d", k), 32'(ten[k]), 32'd16);
      for (int k = 0; k < 4; k++) check($sformatf("rot_gap%0d", k), 32'(gap[k]), 32'd3);
    end
    req[0] = 4'b0000;
    repeat (4) step();

    // Hold limit 4 with no competitor: grant stays continuous.
    req[1] = 4'b0010;
    wait_gnt(1, 4'b0010, 10, "h4_first");
    drops = 0;
    repeat (50) begin
      step();
      if (gnt[1] != 4'b0010) drops++;
    end
    check("h4_continuous", 32'(drops), 32'd0);
    req[1] = 4'b1010;
    n = 0;
    while (gnt[1][1] && n < 10) begin step(); n++; end
    check("h4_preempt_within4", 32'(n >= 1 && n <= 4), 32'd1);
    m = 0;
    while (gnt[1] !== 4'b1000 && m < 20) begin step(); m++; end
    check("h4_handoff_gap", 32'(m), 32'd3);
    req[1] = 4'b0000;
    repeat (6) step();

    // One-cycle pulse during a 3-cycle settle aborts; pointer unchanged.
    rst[2] = 1'b1; step(); rst[2] = 1'b0;
    req[2] = 4'b0001;
    step();
    check("abort_busy_settle", 32'(busy[2]), 32'd1);
    req[2] = 4'b0000;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (gnt[2] != 4'b0000) seen = 1'b1;
    end
    check("abort_no_gnt", 32'(seen), 32'd0);
    check("abort_idle", 32'(busy[2]), 32'd0);
    req[2] = 4'b0011;
    n = 0;
    while (gnt[2] == 4'b0000 && n < 12) begin step(); n++; end
    check("abort_next_winner", 32'(gnt[2]), 32'h1);
    req[2] = 4'b0000;
    repeat (6) step();

    // Reset pulse in the middle of a grant, then re-sequencing from idle.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    req[0] = 4'b0100;
    wait_gnt(0, 4'b0100, 10, "midrst_first");
    step(); step();
    rst[0] = 1'b1;
    step();
    check("midrst_gnt", 32'(gnt[0]), 32'd0);
    check("midrst_noe", 32'(noe[0]), 32'd1);
    check("midrst_sel", 32'(sel[0]), 32'd0);
    rst[0] = 1'b0;
    step();
    check("midrst_resel", 32'(sel[0]), 32'd2);
    check("midrst_regnt_early", 32'(gnt[0]), 32'd0);
    step();
    check("midrst_regnt", 32'(gnt[0]), 32'h4);
    req[0] = 4'b0000;

    // Random request toggling with rare resets against the model.
    repeat (600) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = req[i] ^ (4'b0001 << $urandom_range(0, 3));
        rst[i] = ($urandom_range(0, 149) == 0);
      end
      step();
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
